// File: rtl/uart_rx_frame_ctrl.sv
// Purpose : frame parser behind the UART byte receiver (SYNC, LEN, payload, checksum) with a
//           payload buffer held for the processor until acknowledged.
// Latency : error/valid flags registered one cycle after the deciding byte; rd_data one cycle after rd_addr.
// Backpr. : none upstream (rx_new cannot stall); bytes arriving while a frame is held are dropped (overrun).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rx_data, rx_new     byte stream from the UART receiver (rx_new is a 1-cycle strobe)
//   rd_addr, rd_data    payload buffer read port, registered
//   frame_len           payload length of the held frame
//   frame_valid         a checksum-good frame is held in the buffer
//   frame_ack           processor releases the held frame (1-cycle pulse)
//   csum_err, len_err, timeout_err, overrun   1-cycle error pulses
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         ADDR_W      = 4,
  parameter int         TIMEOUT_CYC = 26042
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_new,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              csum_err,
  output logic              len_err,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  // Sized to the full address space so any rd_addr is a legal index.
  logic [7:0]        mem [0:(2**ADDR_W)-1];

  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        sum;
  logic [CNT_W-1:0]  cnt;

  logic [7:0]        sum_add;
  logic              in_frame;
  logic              to_hit;
  logic              wr_en;
  logic              ev_accept;
  logic              ev_len_err;
  logic              ev_csum_err;
  logic              ev_timeout;
  logic              ev_overrun;

  assign sum_add  = sum + rx_data;
  assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  // A byte arriving on the last allowed cycle wins over the timeout.
  assign to_hit   = in_frame && !rx_new && (cnt == CNT_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    ev_accept   = 1'b0;
    ev_len_err  = 1'b0;
    ev_csum_err = 1'b0;
    ev_timeout  = 1'b0;
    ev_overrun  = 1'b0;
    case (state)
      S_HUNT: begin
        if (rx_new && (rx_data == SYNC_BYTE)) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (rx_new) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            ev_len_err = 1'b1;
            state_nxt  = S_HUNT;
          end else begin
            state_nxt  = S_DATA;
          end
        end else if (to_hit) begin
          ev_timeout = 1'b1;
          state_nxt  = S_HUNT;
        end
      end
      S_DATA: begin
        if (rx_new) begin
          wr_en = 1'b1;
          if ({1'b0, idx} == (len - 1'b1)) state_nxt = S_CSUM;
        end else if (to_hit) begin
          ev_timeout = 1'b1;
          state_nxt  = S_HUNT;
        end
      end
      S_CSUM: begin
        if (rx_new) begin
          if (sum_add == 8'd0) begin
            ev_accept = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            ev_csum_err = 1'b1;
            state_nxt   = S_HUNT;
          end
        end else if (to_hit) begin
          ev_timeout = 1'b1;
          state_nxt  = S_HUNT;
        end
      end
      S_HOLD: begin
        // Buffer is frozen: any byte is dropped, even in the ack cycle.
        if (rx_new)    ev_overrun = 1'b1;
        if (frame_ack) state_nxt  = S_HUNT;
      end
      default: state_nxt = S_HUNT;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      len         <= '0;
      idx         <= '0;
      sum         <= '0;
      cnt         <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      csum_err    <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      rd_data     <= '0;
    end else begin
      // Idle-gap counter: only meaningful mid-frame, restarted by every byte.
      if (in_frame && !rx_new) cnt <= cnt + 1'b1;
      else                     cnt <= '0;

      if (state_nxt == S_DATA && state == S_LEN) begin
        len <= rx_data[ADDR_W:0];
        sum <= rx_data;
        idx <= '0;
      end

      if (wr_en) begin
        sum <= sum_add;
        idx <= idx + 1'b1;
      end

      if (ev_accept) frame_len <= len;

      frame_valid <= (state_nxt == S_HOLD);
      csum_err    <= ev_csum_err;
      len_err     <= ev_len_err;
      timeout_err <= ev_timeout;
      overrun     <= ev_overrun;
      rd_data     <= mem[rd_addr];
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  localparam int T = 26042;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_new = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic [4:0] frame_len;
  logic       frame_valid;
  logic       frame_ack = 1'b0;
  logic       csum_err, len_err, timeout_err, overrun;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_new(rx_new),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_len(frame_len),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .csum_err(csum_err), .len_err(len_err), .timeout_err(timeout_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // err field order: {csum_err, len_err, timeout_err, overrun}
  typedef struct {
    logic       r;
    logic       n;
    logic [7:0] d;
    logic [3:0] a;
    logic       k;
    logic       v;
    logic [4:0] fl;
    logic [3:0] e;
    logic       crd;
    logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic n, input logic [7:0] d, input logic [3:0] a,
                     input logic k, input logic v, input logic [4:0] fl, input logic [3:0] e,
                     input logic crd, input logic [7:0] rd);
    vec_t t;
    t.r = r; t.n = n; t.d = d; t.a = a; t.k = k;
    t.v = v; t.fl = fl; t.e = e; t.crd = crd; t.rd = rd;
    vq.push_back(t);
  endtask

  // byte strobe
  task automatic bi(input logic [7:0] d, input logic v, input logic [4:0] fl, input logic [3:0] e);
    add(1'b0, 1'b1, d, 4'd0, 1'b0, v, fl, e, 1'b0, 8'h00);
  endtask
  // idle cycle
  task automatic id(input logic v, input logic [4:0] fl);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, v, fl, 4'b0000, 1'b0, 8'h00);
  endtask
  // buffer read
  task automatic rdv(input logic [3:0] a, input logic v, input logic [4:0] fl, input logic [7:0] rd);
    add(1'b0, 1'b0, 8'h00, a, 1'b0, v, fl, 4'b0000, 1'b1, rd);
  endtask
  // ack, optionally with a byte in the same cycle
  task automatic ak(input logic n, input logic [4:0] fl, input logic [3:0] e);
    add(1'b0, n, 8'h55, 4'd0, 1'b1, 1'b0, fl, e, 1'b0, 8'h00);
  endtask

  // Drive one cycle of inputs at a falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic r, input logic n, input logic [7:0] d, input logic [3:0] a, input logic k);
    rst = r; rx_new = n; rx_data = d; rd_addr = a; frame_ack = k;
    @(negedge clk);
    rst = 1'b0; rx_new = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_good_01_07;
    step(1'b0, 1'b1, 8'hA5, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'h01, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'h07, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'hF8, 4'd0, 1'b0);
  endtask

  initial begin : main
    logic early;
    logic got_to;
    logic [12:0] got_o, exp_o;

    // ---- reset
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 8'h00);
    // ---- good frame A5 03 11 22 33 97
    bi(8'hA5, 0, 0, 0); bi(8'h03, 0, 0, 0); bi(8'h11, 0, 0, 0); bi(8'h22, 0, 0, 0);
    bi(8'h33, 0, 0, 0); bi(8'h97, 1, 3, 0);
    rdv(4'd0, 1, 3, 8'h11); rdv(4'd1, 1, 3, 8'h22); rdv(4'd2, 1, 3, 8'h33);
    // ---- overrun while held, buffer untouched, then ack
    bi(8'h44, 1, 3, 4'b0001); id(1, 3);
    rdv(4'd0, 1, 3, 8'h11); rdv(4'd2, 1, 3, 8'h33);
    ak(0, 3, 0);
    ak(0, 3, 0);                       // ack outside HOLD: no effect
    // ---- bad checksum, then a good frame
    bi(8'hA5, 0, 3, 0); bi(8'h03, 0, 3, 0); bi(8'h11, 0, 3, 0); bi(8'h22, 0, 3, 0);
    bi(8'h33, 0, 3, 0); bi(8'h98, 0, 3, 4'b1000); id(0, 3);
    bi(8'hA5, 0, 3, 0); bi(8'h02, 0, 3, 0); bi(8'h01, 0, 3, 0); bi(8'h02, 0, 3, 0);
    bi(8'hFB, 1, 2, 0);
    rdv(4'd1, 1, 2, 8'h02);
    ak(0, 2, 0);
    // ---- stray bytes, LEN=0, LEN=17
    bi(8'h5A, 0, 2, 0); bi(8'h00, 0, 2, 0);
    bi(8'hA5, 0, 2, 0); bi(8'h00, 0, 2, 4'b0100); id(0, 2);
    bi(8'hA5, 0, 2, 0); bi(8'h11, 0, 2, 4'b0100);
    bi(8'h03, 0, 2, 0);
    // ---- sync value as payload: A5 01 A5 5A
    bi(8'hA5, 0, 2, 0); bi(8'h01, 0, 2, 0); bi(8'hA5, 0, 2, 0); bi(8'h5A, 1, 1, 0);
    rdv(4'd0, 1, 1, 8'hA5);
    ak(0, 1, 0);
    // ---- LEN=MAX_LEN accepted, reset mid-frame, then recover
    bi(8'hA5, 0, 1, 0); bi(8'h10, 0, 1, 0); bi(8'h11, 0, 1, 0);
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 8'h00);
    bi(8'hA5, 0, 0, 0); bi(8'h01, 0, 0, 0); bi(8'h07, 0, 0, 0); bi(8'hF8, 1, 1, 0);
    rdv(4'd0, 1, 1, 8'h07);
    // ---- ack and byte together in HOLD
    ak(1, 1, 4'b0001);
    bi(8'hA5, 0, 1, 0); bi(8'h01, 0, 1, 0); bi(8'h07, 0, 1, 0); bi(8'hF8, 1, 1, 0);
    ak(0, 1, 0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].n, vq[i].d, vq[i].a, vq[i].k);
      got_o = {frame_valid, frame_len, csum_err, len_err, timeout_err, overrun, 3'b000};
      exp_o = {vq[i].v, vq[i].fl, vq[i].e, 3'b000};
      chk($sformatf("vec%0d outputs{valid,len,csum,len,to,ovr}", i), int'(got_o), int'(exp_o));
      if (vq[i].crd) chk($sformatf("vec%0d rd_data", i), int'(rd_data), int'(vq[i].rd));
    end

    // ---- timeout exactly T cycles after the last byte strobe
    step(1'b0, 1'b1, 8'hA5, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'h11, 4'd0, 1'b0);
    early = 1'b0;
    got_to = 1'b0;
    for (int k = 1; k <= T; k++) begin
      step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      if (k < T && timeout_err) early = 1'b1;
      if (k == T) got_to = timeout_err;
    end
    chk("timeout_early", int'(early), 0);
    chk("timeout_at_T", int'(got_to), 1);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    chk("timeout_single_pulse", int'(timeout_err), 0);
    send_good_01_07();
    chk("after_timeout_valid", int'(frame_valid), 1);
    chk("after_timeout_len", int'(frame_len), 1);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    chk("after_timeout_ack", int'(frame_valid), 0);

    // ---- byte on the last allowed cycle beats the timeout
    early = 1'b0;
    step(1'b0, 1'b1, 8'hA5, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 4'd0, 1'b0);
    for (int k = 1; k < T; k++) begin
      step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      if (timeout_err) early = 1'b1;
    end
    step(1'b0, 1'b1, 8'h11, 4'd0, 1'b0);
    if (timeout_err) early = 1'b1;
    step(1'b0, 1'b1, 8'h22, 4'd0, 1'b0);
    step(1'b0, 1'b1, 8'hCB, 4'd0, 1'b0);
    chk("late_byte_no_timeout", int'(early), 0);
    chk("late_byte_frame_valid", int'(frame_valid), 1);
    chk("late_byte_frame_len", int'(frame_len), 2);
    step(1'b0, 1'b0, 8'h00, 4'd1, 1'b1);
    chk("late_byte_rd1", int'(rd_data), 8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
